// File: rtl/vote_trip_handler_if.sv
// Voter-to-trip-handler bundle: voter verdict, failure count and operator ack in,
// latched trip status and host-visible event statistics out.
interface vote_trip_handler_if #(
  parameter int CNT_W = 8
);
  logic             vote_result;
  logic [3:0]       fail_count;
  logic             ack;
  logic             trip;
  logic             pending;
  logic             ack_ready;
  logic             ack_done;
  logic [1:0]       state;
  logic [3:0]       peak_fails;
  logic [CNT_W-1:0] trip_count;

  modport master (
    output vote_result, fail_count, ack,
    input  trip, pending, ack_ready, ack_done, state, peak_fails, trip_count
  );

  modport slave (
    input  vote_result, fail_count, ack,
    output trip, pending, ack_ready, ack_done, state, peak_fails, trip_count
  );
endinterface

// File: rtl/vote_trip_handler.sv
// Persistence-filtered trip latch with clean-recovery window and operator release.
// Trip after PERSIST_CYCLES high samples; no backpressure, every input sampled each edge.
module vote_trip_handler #(
  parameter int PERSIST_CYCLES = 4,
  parameter int CLEAR_CYCLES   = 8,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  vote_trip_handler_if.slave vif
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_PENDING  = 2'd1,
    ST_TRIPPED  = 2'd2,
    ST_CLEARING = 2'd3
  } state_e;

  localparam logic [7:0]       PERSIST_MAX = 8'(PERSIST_CYCLES);
  localparam logic [7:0]       CLEAR_MAX   = 8'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  state_e           state_q, state_d;
  logic [7:0]       persist_q, persist_d;
  logic [7:0]       clean_q, clean_d;
  logic             trip_q, trip_d;
  logic             ack_done_q, ack_done_d;
  logic [3:0]       peak_q, peak_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             ack_ready;
  logic [3:0]       peak_max;
  logic [CNT_W-1:0] count_inc;

  assign ack_ready = (state_q == ST_CLEARING) && (clean_q == CLEAR_MAX);
  assign peak_max  = (vif.fail_count > peak_q) ? vif.fail_count : peak_q;
  assign count_inc = (count_q == CNT_SAT) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    persist_d  = persist_q;
    clean_d    = clean_q;
    trip_d     = trip_q;
    ack_done_d = 1'b0;
    peak_d     = peak_q;
    count_d    = count_q;
    case (state_q)
      ST_NORMAL: begin
        if (vif.vote_result) begin
          peak_d = vif.fail_count;
          if (PERSIST_MAX == 8'd1) begin
            state_d = ST_TRIPPED;
            trip_d  = 1'b1;
            count_d = count_inc;
          end else begin
            state_d   = ST_PENDING;
            persist_d = 8'd1;
          end
        end
      end
      ST_PENDING: begin
        if (vif.vote_result) begin
          peak_d = peak_max;
          if (persist_q + 8'd1 == PERSIST_MAX) begin
            state_d   = ST_TRIPPED;
            trip_d    = 1'b1;
            persist_d = 8'd0;
            count_d   = count_inc;
          end else begin
            persist_d = persist_q + 8'd1;
          end
        end else begin
          state_d   = ST_NORMAL;
          persist_d = 8'd0;
          peak_d    = 4'd0;
        end
      end
      ST_TRIPPED: begin
        peak_d = peak_max;
        if (!vif.vote_result) begin
          state_d = ST_CLEARING;
          clean_d = 8'd1;
        end
      end
      ST_CLEARING: begin
        peak_d = peak_max;
        // A returning fault outranks a simultaneous acknowledge.
        if (vif.vote_result) begin
          state_d = ST_TRIPPED;
          clean_d = 8'd0;
        end else if (vif.ack && ack_ready) begin
          state_d    = ST_NORMAL;
          trip_d     = 1'b0;
          ack_done_d = 1'b1;
          peak_d     = 4'd0;
          clean_d    = 8'd0;
          persist_d  = 8'd0;
        end else if (clean_q != CLEAR_MAX) begin
          clean_d = clean_q + 8'd1;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      persist_q  <= 8'd0;
      clean_q    <= 8'd0;
      trip_q     <= 1'b0;
      ack_done_q <= 1'b0;
      peak_q     <= 4'd0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      persist_q  <= persist_d;
      clean_q    <= clean_d;
      trip_q     <= trip_d;
      ack_done_q <= ack_done_d;
      peak_q     <= peak_d;
      count_q    <= count_d;
    end
  end

  assign vif.trip       = trip_q;
  assign vif.pending    = (state_q == ST_PENDING);
  assign vif.ack_ready  = ack_ready;
  assign vif.ack_done   = ack_done_q;
  assign vif.state      = state_q;
  assign vif.peak_fails = peak_q;
  assign vif.trip_count = count_q;

endmodule

// File: tb/tb_vote_trip_handler.sv
// Two instances (default parameters, and PERSIST=1/CLEAR=1/CNT_W=2) driven with the
// same directed then random stimulus, each checked every cycle against an event-level model.
module tb_vote_trip_handler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vote_trip_handler_if #(.CNT_W(8)) ifa ();
  vote_trip_handler_if #(.CNT_W(2)) ifb ();

  vote_trip_handler #(.PERSIST_CYCLES(4), .CLEAR_CYCLES(8), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .vif (ifa.slave)
  );

  vote_trip_handler #(.PERSIST_CYCLES(1), .CLEAR_CYCLES(1), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .vif (ifb.slave)
  );

  // Model view: run of consecutive highs before a trip, run of lows since the last
  // fault while tripped, the event peak and the number of trips.
  typedef struct {
    bit tripped;
    int highs;
    int lows;
    int peak;
    int count;
    bit done;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, int p, int c, int cmax,
                                  bit r, bit vr, int fc, bit ak);
    model_t n = m;
    n.done = 1'b0;
    if (r) begin
      n = '{default: 0};
    end else if (!m.tripped) begin
      if (vr) begin
        n.highs = m.highs + 1;
        n.peak  = (n.highs == 1) ? fc : ((fc > m.peak) ? fc : m.peak);
        if (n.highs >= p) begin
          n.tripped = 1'b1;
          n.lows    = 0;
          n.count   = (m.count < cmax) ? m.count + 1 : cmax;
        end
      end else begin
        n.highs = 0;
        n.peak  = 0;
      end
    end else begin
      n.peak = (fc > m.peak) ? fc : m.peak;
      if (vr) begin
        n.lows = 0;
      end else if (ak && m.lows >= c) begin
        n.tripped = 1'b0;
        n.highs   = 0;
        n.lows    = 0;
        n.peak    = 0;
        n.done    = 1'b1;
      end else begin
        n.lows = m.lows + 1;
      end
    end
    return n;
  endfunction

  function automatic int m_state(model_t m);
    if (!m.tripped) return (m.highs > 0) ? 1 : 0;
    return (m.lows > 0) ? 3 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string nm, input model_t m, input int c,
                               input logic [1:0] st, input logic tr, input logic pd,
                               input logic rdy, input logic dn, input logic [3:0] pk,
                               input logic [31:0] cnt);
    check({nm, ".state"},      32'(st),  32'(m_state(m)));
    check({nm, ".trip"},       32'(tr),  32'(m.tripped));
    check({nm, ".pending"},    32'(pd),  32'(m_state(m) == 1));
    check({nm, ".ack_ready"},  32'(rdy), 32'(m.tripped && m.lows >= c));
    check({nm, ".ack_done"},   32'(dn),  32'(m.done));
    check({nm, ".peak_fails"}, 32'(pk),  32'(m.peak));
    check({nm, ".trip_count"}, cnt,      32'(m.count));
  endtask

  task automatic cycle(input bit r, input bit vr, input logic [3:0] fc, input bit ak);
    rst = r;
    ifa.vote_result = vr; ifa.fail_count = fc; ifa.ack = ak;
    ifb.vote_result = vr; ifb.fail_count = fc; ifb.ack = ak;
    @(posedge clk);
    ma = step(ma, 4, 8, 255, r, vr, int'(fc), ak);
    mb = step(mb, 1, 1, 3, r, vr, int'(fc), ak);
    #1;
    check_outputs("a", ma, 8, ifa.state, ifa.trip, ifa.pending, ifa.ack_ready,
                  ifa.ack_done, ifa.peak_fails, 32'(ifa.trip_count));
    check_outputs("b", mb, 1, ifb.state, ifb.trip, ifb.pending, ifb.ack_ready,
                  ifb.ack_done, ifb.peak_fails, 32'(ifb.trip_count));
  endtask

  initial begin
    logic [3:0] fcs [4];
    int  phase_left;
    int  mode;
    bit  vr;
    fcs = '{4'd2, 4'd5, 4'd3, 4'd3};
    ma = '{default: 0};
    mb = '{default: 0};
    ifa.vote_result = 1'b0; ifa.fail_count = 4'd0; ifa.ack = 1'b0;
    ifb.vote_result = 1'b0; ifb.fail_count = 4'd0; ifb.ack = 1'b0;

    cycle(1, 0, 0, 0);
    cycle(1, 1, 4'd9, 1);
    check("reset.a.state", 32'(ifa.state), 32'd0);
    check("reset.b.count", 32'(ifb.trip_count), 32'd0);

    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'd3, 0);
    check("abort.a.pending", 32'(ifa.pending), 32'd1);
    cycle(0, 0, 0, 0);
    check("abort.a.state", 32'(ifa.state), 32'd0);
    check("abort.a.peak", 32'(ifa.peak_fails), 32'd0);

    for (int i = 0; i < 4; i++) cycle(0, 1, fcs[i], 0);
    check("trip.a.trip", 32'(ifa.trip), 32'd1);
    check("trip.a.count", 32'(ifa.trip_count), 32'd1);
    check("trip.a.peak", 32'(ifa.peak_fails), 32'd5);
    check("trip.a.state", 32'(ifa.state), 32'd2);

    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    check("clear.a.state", 32'(ifa.state), 32'd3);
    cycle(0, 1, 0, 0);
    check("refault.a.state", 32'(ifa.state), 32'd2);
    check("refault.a.count", 32'(ifa.trip_count), 32'd1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    check("window.a.ready", 32'(ifa.ack_ready), 32'd1);

    cycle(0, 1, 0, 1);
    check("ackfault.a.state", 32'(ifa.state), 32'd2);
    check("ackfault.a.done", 32'(ifa.ack_done), 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("release.a.done", 32'(ifa.ack_done), 32'd1);
    check("release.a.trip", 32'(ifa.trip), 32'd0);
    check("release.a.state", 32'(ifa.state), 32'd0);
    cycle(0, 0, 0, 1);
    check("release.a.done_pulse", 32'(ifa.ack_done), 32'd0);

    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 4'd7, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
    end
    check("sat.b.count", 32'(ifb.trip_count), 32'd3);

    for (int i = 0; i < 4; i++) cycle(0, 1, 4'd6, 0);
    cycle(1, 1, 4'd6, 0);
    check("midtrip_rst.a.trip", 32'(ifa.trip), 32'd0);
    check("midtrip_rst.a.count", 32'(ifa.trip_count), 32'd0);
    check("midtrip_rst.b.count", 32'(ifb.trip_count), 32'd0);

    phase_left = 0;
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (phase_left == 0) begin
        mode = int'($urandom_range(0, 3));
        phase_left = int'($urandom_range(1, 20));
      end
      phase_left--;
      case (mode)
        0:       vr = 1'b0;
        1:       vr = 1'b1;
        2:       vr = ($urandom_range(0, 1) == 0);
        default: vr = ($urandom_range(0, 9) == 0);
      endcase
      cycle(($urandom_range(0, 799) == 0), vr, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
